// File: rtl/ticket_change_dispenser_pkg.sv
// Shared definitions for the ticket counter change dispenser: coin encodings,
// FSM states and the coin-value lookup.
package ticket_change_dispenser_pkg;

    // Coin codes follow the ticket counter's hopper encoding.
    typedef enum logic [2:0] {
        COIN_NONE = 3'b000,
        COIN_1    = 3'b001,
        COIN_2    = 3'b010,
        COIN_5    = 3'b101
    } coin_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT_ACK,
        ST_DONE,
        ST_FAULT
    } state_e;

    localparam logic [2:0] VAL_1 = 3'd1;
    localparam logic [2:0] VAL_2 = 3'd2;
    localparam logic [2:0] VAL_5 = 3'd5;

    function automatic logic [2:0] coin_value(input coin_e code);
        case (code)
            COIN_1:  coin_value = VAL_1;
            COIN_2:  coin_value = VAL_2;
            COIN_5:  coin_value = VAL_5;
            default: coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ticket_change_dispenser_select.sv
// Combinational largest-first coin pick, limited by what the hopper holds.
module ticket_change_dispenser_select
    import ticket_change_dispenser_pkg::*;
#(
    parameter int AMT_W = 4,
    parameter int CNT_W = 6
) (
    input  logic [AMT_W-1:0] remain,
    input  logic [CNT_W-1:0] cnt1,
    input  logic [CNT_W-1:0] cnt2,
    input  logic [CNT_W-1:0] cnt5,
    output coin_e            code,
    output logic [AMT_W-1:0] value,
    output logic             none
);

    // A coin is only offered when its value fits in remain, so remain never underflows.
    always_comb begin
        code = COIN_NONE;
        if (remain >= AMT_W'(5) && cnt5 != '0) begin
            code = COIN_5;
        end else if (remain >= AMT_W'(2) && cnt2 != '0) begin
            code = COIN_2;
        end else if (remain != '0 && cnt1 != '0) begin
            code = COIN_1;
        end
    end

    assign value = AMT_W'(coin_value(code));
    assign none  = (code == COIN_NONE);

endmodule

// File: rtl/ticket_change_dispenser.sv
// Change dispenser: accepts a change amount, pays it out one coin at a time
// through the hopper handshake, and reports completion, shortfall or timeout.
module ticket_change_dispenser
    import ticket_change_dispenser_pkg::*;
#(
    parameter int AMT_W       = 4,
    parameter int CNT_W       = 6,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amt,
    output logic             req_ready,
    input  logic             inv_load,
    input  logic [CNT_W-1:0] inv_c1,
    input  logic [CNT_W-1:0] inv_c2,
    input  logic [CNT_W-1:0] inv_c5,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt5,
    output logic             coin_valid,
    output logic [2:0]       coin_code,
    input  logic             coin_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remain_out,
    output logic             fault,
    input  logic             fault_clr
);

    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    state_e           state, state_nxt;
    coin_e            coin_q, coin_nxt;
    logic [AMT_W-1:0] coin_val_q, coin_val_nxt;
    logic [AMT_W-1:0] remain, remain_nxt, remain_out_nxt;
    logic [CNT_W-1:0] cnt1_nxt, cnt2_nxt, cnt5_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;

    coin_e            pick_code;
    logic [AMT_W-1:0] pick_value;
    logic             pick_none;

    ticket_change_dispenser_select #(
        .AMT_W (AMT_W),
        .CNT_W (CNT_W)
    ) u_select (
        .remain (remain),
        .cnt1   (cnt1),
        .cnt2   (cnt2),
        .cnt5   (cnt5),
        .code   (pick_code),
        .value  (pick_value),
        .none   (pick_none)
    );

    // NOTE: every register is reset and updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            coin_q     <= COIN_NONE;
            coin_val_q <= '0;
            remain     <= '0;
            remain_out <= '0;
            cnt1       <= '0;
            cnt2       <= '0;
            cnt5       <= '0;
            timer      <= '0;
        end else begin
            state      <= state_nxt;
            coin_q     <= coin_nxt;
            coin_val_q <= coin_val_nxt;
            remain     <= remain_nxt;
            remain_out <= remain_out_nxt;
            cnt1       <= cnt1_nxt;
            cnt2       <= cnt2_nxt;
            cnt5       <= cnt5_nxt;
            timer      <= timer_nxt;
        end
    end

    // NOTE: every variable gets a hold value first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        coin_nxt       = coin_q;
        coin_val_nxt   = coin_val_q;
        remain_nxt     = remain;
        remain_out_nxt = remain_out;
        cnt1_nxt       = cnt1;
        cnt2_nxt       = cnt2;
        cnt5_nxt       = cnt5;
        timer_nxt      = timer;

        case (state)
            ST_IDLE: begin
                if (inv_load) begin
                    cnt1_nxt = inv_c1;
                    cnt2_nxt = inv_c2;
                    cnt5_nxt = inv_c5;
                end else if (req_valid) begin
                    remain_nxt = req_amt;
                    state_nxt  = (req_amt == '0) ? ST_DONE : ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (!pick_none) begin
                    coin_nxt     = pick_code;
                    coin_val_nxt = pick_value;
                    timer_nxt    = '0;
                    state_nxt    = ST_WAIT_ACK;
                end else begin
                    state_nxt = ST_DONE;
                end
            end

            ST_WAIT_ACK: begin
                // An ack arriving on the last timeout cycle still counts.
                if (coin_ack) begin
                    remain_nxt = remain - coin_val_q;
                    case (coin_q)
                        COIN_1:  cnt1_nxt = cnt1 - CNT_W'(1);
                        COIN_2:  cnt2_nxt = cnt2 - CNT_W'(1);
                        COIN_5:  cnt5_nxt = cnt5 - CNT_W'(1);
                        default: ;
                    endcase
                    coin_nxt  = COIN_NONE;
                    state_nxt = (remain_nxt == '0) ? ST_DONE : ST_SELECT;
                end else if (timer == TMR_LAST) begin
                    coin_nxt  = COIN_NONE;
                    state_nxt = ST_FAULT;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end

            ST_DONE: state_nxt = ST_IDLE;

            ST_FAULT: begin
                if (fault_clr) state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase

        // remain_out shows the final remain during DONE and holds it afterwards.
        if (state_nxt == ST_DONE) remain_out_nxt = remain_nxt;
    end

    // req_ready is held low while reset is asserted, like every other output.
    assign req_ready  = rst && (state == ST_IDLE) && !inv_load;
    assign coin_valid = (coin_q != COIN_NONE);
    assign coin_code  = coin_q;
    assign done       = (state == ST_DONE);
    assign short      = done && (remain != '0);
    assign fault      = (state == ST_FAULT);

endmodule

// File: tb/tb_ticket_change_dispenser.sv
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized run against a greedy change-making model.
module tb_ticket_change_dispenser;

    localparam int AMT_W       = 4;
    localparam int CNT_W       = 6;
    localparam int ACK_TIMEOUT = 15;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic [AMT_W-1:0] req_amt;
    logic             req_ready;
    logic             inv_load;
    logic [CNT_W-1:0] inv_c1, inv_c2, inv_c5;
    logic [CNT_W-1:0] cnt1, cnt2, cnt5;
    logic             coin_valid;
    logic [2:0]       coin_code;
    logic             coin_ack;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remain_out;
    logic             fault;
    logic             fault_clr;

    ticket_change_dispenser #(
        .AMT_W       (AMT_W),
        .CNT_W       (CNT_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_amt    (req_amt),
        .req_ready  (req_ready),
        .inv_load   (inv_load),
        .inv_c1     (inv_c1),
        .inv_c2     (inv_c2),
        .inv_c5     (inv_c5),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .cnt5       (cnt5),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .coin_ack   (coin_ack),
        .done       (done),
        .short      (short),
        .remain_out (remain_out),
        .fault      (fault),
        .fault_clr  (fault_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Observations of one request, filled by run_request.
    logic [2:0] obs_codes[$];
    logic [2:0] exp_codes[$];
    int         obs_done_cyc;
    int         obs_last_ack;
    bit         obs_done_seen;
    logic       obs_short;
    logic [3:0] obs_rem;
    logic [3:0] obs_rem_after;

    task automatic load_stock(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        inv_load = 1'b1;
        inv_c1 = a;
        inv_c2 = b;
        inv_c5 = c;
        @(negedge clk);
        inv_load = 1'b0;
    endtask

    // Called at a falling edge in IDLE; acks each coin after ack_lat extra cycles.
    task automatic run_request(input logic [3:0] amt, input int ack_lat);
        int  k;
        int  cyc;
        int  waited;
        bit  finished;
        obs_codes.delete();
        obs_done_seen = 0;
        obs_done_cyc  = -1;
        obs_last_ack  = 0;
        obs_short     = 1'b0;
        obs_rem       = '0;
        req_valid = 1'b1;
        req_amt   = amt;
        #1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("req_ready_for_request", req_ready, 1);
        cyc      = 0;
        waited   = 0;
        finished = 0;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            req_valid = 1'b0;
            coin_ack  = 1'b0;
            cyc++;
            if (done) begin
                finished      = 1;
                obs_done_seen = 1;
                obs_done_cyc  = cyc;
                obs_short     = short;
                obs_rem       = remain_out;
            end else if (coin_valid) begin
                if (waited == 0) begin
                    obs_codes.push_back(coin_code);
                    check("coin_latency", cyc - obs_last_ack, 2);
                end else begin
                    check("coin_code_stable", coin_code, obs_codes[$]);
                end
                if (waited >= ack_lat) begin
                    coin_ack     = 1'b1;
                    waited       = 0;
                    obs_last_ack = cyc;
                end else begin
                    waited++;
                end
            end
        end
        req_valid = 1'b0;
        check("done_seen", obs_done_seen, 1);
        @(negedge clk);
        coin_ack = 1'b0;
        check("done_single_pulse", done, 0);
        check("short_low_after_done", short, 0);
        obs_rem_after = remain_out;
    endtask

    task automatic verify(input string tag, input logic sh, input logic [3:0] rem,
                          input logic [5:0] e1, input logic [5:0] e2, input logic [5:0] e5);
        check({tag, "_ncoins"}, obs_codes.size(), exp_codes.size());
        for (int i = 0; i < exp_codes.size() && i < obs_codes.size(); i++)
            check({tag, "_code"}, obs_codes[i], exp_codes[i]);
        check({tag, "_short"}, obs_short, sh);
        check({tag, "_remain_out"}, obs_rem, rem);
        check({tag, "_remain_hold"}, obs_rem_after, rem);
        check({tag, "_done_latency"}, obs_done_cyc - obs_last_ack, sh ? 2 : 1);
        check({tag, "_cnt1"}, cnt1, e1);
        check({tag, "_cnt2"}, cnt2, e2);
        check({tag, "_cnt5"}, cnt5, e5);
    endtask

    typedef struct {
        logic [5:0]  c1, c2, c5;
        logic [3:0]  amt;
        int          ack;
        int          n;
        logic [11:0] coins;
        logic        sh;
        logic [3:0]  rem;
        logic [5:0]  e1, e2, e5;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] m1, m2, m5;
        logic [3:0] amt, rem;
        int         vcount, k;

        vecs[0] = '{6'd3,  6'd3,  6'd2,  4'd8,  0,  3, 12'b101_010_001_000, 1'b0, 4'd0,  6'd2,  6'd2,  6'd1};
        vecs[1] = '{6'd3,  6'd0,  6'd0,  4'd4,  1,  3, 12'b001_001_001_000, 1'b1, 4'd1,  6'd0,  6'd0,  6'd0};
        vecs[2] = '{6'd1,  6'd1,  6'd1,  4'd0,  0,  0, 12'b000_000_000_000, 1'b0, 4'd0,  6'd1,  6'd1,  6'd1};
        vecs[3] = '{6'd0,  6'd4,  6'd1,  4'd9,  2,  3, 12'b101_010_010_000, 1'b0, 4'd0,  6'd0,  6'd2,  6'd0};
        vecs[4] = '{6'd0,  6'd2,  6'd0,  4'd3,  0,  1, 12'b010_000_000_000, 1'b1, 4'd1,  6'd0,  6'd1,  6'd0};
        vecs[5] = '{6'd5,  6'd0,  6'd3,  4'd15, 3,  3, 12'b101_101_101_000, 1'b0, 4'd0,  6'd5,  6'd0,  6'd0};
        vecs[6] = '{6'd63, 6'd63, 6'd63, 4'd7,  0,  2, 12'b101_010_000_000, 1'b0, 4'd0,  6'd63, 6'd62, 6'd62};
        vecs[7] = '{6'd0,  6'd0,  6'd0,  4'd6,  0,  0, 12'b000_000_000_000, 1'b1, 4'd6,  6'd0,  6'd0,  6'd0};
        vecs[8] = '{6'd2,  6'd1,  6'd0,  4'd15, 1,  3, 12'b010_001_001_000, 1'b1, 4'd11, 6'd0,  6'd0,  6'd0};
        vecs[9] = '{6'd0,  6'd0,  6'd1,  4'd5,  14, 1, 12'b101_000_000_000, 1'b0, 4'd0,  6'd0,  6'd0,  6'd0};

        rst = 1'b0;
        req_valid = 1'b0;
        req_amt = '0;
        inv_load = 1'b0;
        inv_c1 = '0;
        inv_c2 = '0;
        inv_c5 = '0;
        coin_ack = 1'b0;
        fault_clr = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_coin_valid", coin_valid, 0);
        check("rst_coin_code", coin_code, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_cnt5", cnt5, 0);
        check("rst_remain_out", remain_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1);

        // Directed table.
        for (int v = 0; v < 10; v++) begin
            load_stock(vecs[v].c1, vecs[v].c2, vecs[v].c5);
            run_request(vecs[v].amt, vecs[v].ack);
            exp_codes.delete();
            for (int i = 0; i < vecs[v].n; i++) exp_codes.push_back(vecs[v].coins[11-3*i -: 3]);
            verify($sformatf("vec%0d", v), vecs[v].sh, vecs[v].rem, vecs[v].e1, vecs[v].e2, vecs[v].e5);
        end

        // inv_load collides with a request: load wins, request served next cycle.
        inv_load = 1'b1;
        inv_c1 = 6'd0;
        inv_c2 = 6'd0;
        inv_c5 = 6'd1;
        req_valid = 1'b1;
        req_amt = 4'd5;
        #1;
        check("load_blocks_ready", req_ready, 0);
        @(negedge clk);
        inv_load = 1'b0;
        check("load_cnt5", cnt5, 1);
        run_request(4'd5, 0);
        exp_codes.delete();
        exp_codes.push_back(3'b101);
        verify("load_then_req", 1'b0, 4'd0, 6'd0, 6'd0, 6'd0);

        // Hopper never acks: fault after ACK_TIMEOUT cycles of coin_valid.
        load_stock(6'd0, 6'd0, 6'd2);
        req_valid = 1'b1;
        req_amt = 4'd5;
        #1;
        check("timeout_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        vcount = 0;
        k = 0;
        while (!fault && k < 100) begin
            if (coin_valid) vcount++;
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", vcount, ACK_TIMEOUT);
        check("fault_set", fault, 1);
        check("fault_coin_valid", coin_valid, 0);
        check("fault_coin_code", coin_code, 0);
        check("fault_cnt5", cnt5, 2);
        check("fault_req_ready", req_ready, 0);
        check("fault_done", done, 0);
        coin_ack = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        req_valid = 1'b0;
        check("fault_sticky", fault, 1);
        check("fault_ack_ignored", cnt5, 2);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("fault_cleared", fault, 0);
        check("fault_clr_ready", req_ready, 1);
        check("fault_clr_no_done", done, 0);
        run_request(4'd5, 0);
        exp_codes.delete();
        exp_codes.push_back(3'b101);
        verify("after_fault", 1'b0, 4'd0, 6'd0, 6'd0, 6'd1);

        // Leave a nonzero remain_out, then reset asynchronously mid-payout.
        load_stock(6'd0, 6'd0, 6'd0);
        run_request(4'd3, 0);
        exp_codes.delete();
        verify("empty_hopper", 1'b1, 4'd3, 6'd0, 6'd0, 6'd0);
        load_stock(6'd2, 6'd2, 6'd2);
        req_valid = 1'b1;
        req_amt = 4'd4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_coin_valid", coin_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_coin_valid", coin_valid, 0);
        check("async_rst_coin_code", coin_code, 0);
        check("async_rst_cnt1", cnt1, 0);
        check("async_rst_cnt2", cnt2, 0);
        check("async_rst_cnt5", cnt5, 0);
        check("async_rst_remain_out", remain_out, 0);
        check("async_rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_done", done, 0);
            check("post_rst_no_coin", coin_valid, 0);
        end
        check("post_rst_ready", req_ready, 1);

        // Randomized requests against a greedy change-making model.
        m1 = 6'($urandom_range(0, 4));
        m2 = 6'($urandom_range(0, 4));
        m5 = 6'($urandom_range(0, 4));
        load_stock(m1, m2, m5);
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                m1 = 6'($urandom_range(0, 4));
                m2 = 6'($urandom_range(0, 4));
                m5 = 6'($urandom_range(0, 4));
                load_stock(m1, m2, m5);
            end
            amt = 4'($urandom_range(0, 15));
            rem = amt;
            exp_codes.delete();
            while (rem != 0) begin
                if (rem >= 5 && m5 > 0) begin
                    exp_codes.push_back(3'b101);
                    rem = rem - 4'd5;
                    m5 = m5 - 6'd1;
                end else if (rem >= 2 && m2 > 0) begin
                    exp_codes.push_back(3'b010);
                    rem = rem - 4'd2;
                    m2 = m2 - 6'd1;
                end else if (m1 > 0) begin
                    exp_codes.push_back(3'b001);
                    rem = rem - 4'd1;
                    m1 = m1 - 6'd1;
                end else begin
                    break;
                end
            end
            run_request(amt, $urandom_range(0, 3));
            verify($sformatf("rand%0d", it), rem != 0, rem, m1, m2, m5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
